piso_serializer: RTL and testbench

//  Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load port and

---
 rtl/piso_pkg.sv | 23 ++
 rtl/piso_bit_counter.sv | 36 +++
 rtl/piso_serializer.sv | 143 ++++++++++++++
 tb/tb_piso_serializer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer.
//   state_t        : FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH  : default data bits per frame
//   FRAME_LEN()    : serial bits per frame for a given data width.
//                    With PISO_PARITY_EN defined, this adds one trailing even-parity bit.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int FRAME_LEN(input int width);
`ifdef PISO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one serial frame.
// The counter either loads zero or increments, and it saturates at FRAME-1.
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-low reset; forces count to 0
//   clear  in   load zero (a new frame starts or the frame ends)
//   inc    in   advance to the next bit position; ignored at terminal count
//   count  out  current bit position, 0..FRAME-1
//   tc     out  count == FRAME-1 (the final bit of the frame)
module piso_bit_counter #(
  parameter int FRAME = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     inc,
  output logic [$clog2(FRAME)-1:0] count,
  output logic                     tc
);

  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out transmitter.
// The block accepts a WIDTH-bit word over a valid/ready port and sends it out LSB first,
// one bit per clk. Each bit comes with a valid strobe, and the final bit of the frame
// also carries an end-of-frame marker.
// When a new word is accepted during the last-bit cycle, the next frame follows with no gap.
// Build option: define PISO_PARITY_EN to append one even-parity bit after the data bits.
// With the option defined, ser_last moves to that parity bit.
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-low reset (aborts any frame in flight)
//   load_valid in   upstream presents a word
//   load_data  in   word to transmit; sampled only on accept
//   load_ready out  word can be accepted this cycle
//   ser_out    out  serial data bit (registered)
//   ser_valid  out  ser_out carries a frame bit
//   ser_last   out  current bit is the final bit of the frame
//   busy       out  frame in progress
//
// state | meaning
// IDLE  | no frame on the line; outputs quiet, ready for a word
// SHIFT | frame bits on ser_out; a new word is accepted only on the last bit
import piso_pkg::*;

module piso_serializer #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int FRAME = FRAME_LEN(WIDTH);
  localparam int CW    = $clog2(FRAME);

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    count;
  logic             tc;
  logic             accept;
  logic             next_bit;
  logic             cnt_clear, cnt_inc;
  logic             ser_out_next, ser_valid_next;

  piso_bit_counter #(.FRAME(FRAME)) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (count),
    .tc    (tc)
  );

  // The count is meaningful only while bits are on the line.
  assign ser_last   = ser_valid && tc;
  assign load_ready = reset && ((state == IDLE) || ser_last);
  assign accept     = load_valid && load_ready;
  assign busy       = (state != IDLE);

`ifdef PISO_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^load_data;
    end
  end

  // After data bit WIDTH-1, the next bit on the line is the parity bit.
  assign next_bit = (count == CW'(WIDTH - 1)) ? parity_q : shift_q[0];
`else
  assign next_bit = shift_q[0];
`endif

  always_comb begin
    state_next   = state;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    ser_out_next = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next   = SHIFT;
          cnt_clear    = 1'b1;
          ser_out_next = load_data[0];
        end
      end
      SHIFT: begin
        if (accept) begin
          // Accept happens only on the last bit, so the next frame starts with no gap.
          cnt_clear    = 1'b1;
          ser_out_next = load_data[0];
        end else if (ser_last) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else begin
          cnt_inc      = 1'b1;
          ser_out_next = next_bit;
        end
      end
      default: state_next = IDLE;
    endcase
    ser_valid_next = (state_next == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bit 0 goes straight to ser_out on accept.
  // The shift register therefore holds the bits that are still to be sent.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
    end else if (accept) begin
      shift_q <= load_data >> 1;
    end else if (cnt_inc) begin
      shift_q <= shift_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      ser_out   <= ser_out_next;
      ser_valid <= ser_valid_next;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer.
// A scoreboard queue receives the expected bits of every accepted word.
// A negedge monitor pops that queue and compares against each valid bit on the line.
// Directed stream checks compare against hand-computed bit sequences.
// A serial-in receiver model checks each word after its last bit.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int W  = 4;
  localparam int FR = FRAME_LEN(W);

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready, ser_out, ser_valid, ser_last, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] word_q[$];
  logic [W-1:0] rx = '0;
  logic [W-1:0] wexp;
  exp_t         e_push, e_pop;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  // Expected-value generation on accept; receiver model; queue flush on reset
  always @(posedge clk) begin
    if (!reset) begin
      exp_q.delete();
      word_q.delete();
      rx <= '0;
    end else begin
      if (ser_valid) begin
        rx <= {ser_out, rx[W-1:1]};
`ifndef PISO_PARITY_EN
        if (ser_last) begin
          if (word_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL loopback_no_word actual=frame_end required=pending_word");
          end else begin
            wexp = word_q.pop_front();
            check("loopback_word", {ser_out, rx[W-1:1]}, wexp);
          end
        end
`endif
      end
      if (load_valid && load_ready) begin
        for (int i = 0; i < W; i++) begin
          e_push.b    = load_data[i];
          e_push.last = (FR == W) && (i == W - 1);
          exp_q.push_back(e_push);
        end
`ifdef PISO_PARITY_EN
        e_push.b    = ^load_data;
        e_push.last = 1'b1;
        exp_q.push_back(e_push);
`else
        word_q.push_back(load_data);
`endif
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (ser_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_bit actual=ser_valid required=no_bit time=%0t", $time);
      end else begin
        e_pop = exp_q.pop_front();
        check("sb_ser_out", ser_out, e_pop.b);
        check("sb_ser_last", ser_last, e_pop.last);
      end
    end else begin
      check("idle_ser_out", ser_out, 1'b0);
      check("idle_ser_last", ser_last, 1'b0);
    end
    if (reset && busy && !ser_last) check("ready_low_mid_frame", load_ready, 1'b0);
    if (reset && ser_last) check("ready_on_last", load_ready, 1'b1);
  end

  task automatic wait_accept();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (load_ready && load_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout actual=no_accept required=accept");
  endtask

  task automatic expect_stream(input string name, input int n, input logic [15:0] bits,
                               input logic [15:0] lasts);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({name, "_valid"}, ser_valid, 1'b1);
      check({name, "_bit"}, ser_out, bits[i]);
      check({name, "_last"}, ser_last, lasts[i]);
    end
  endtask

  initial begin
    // Reset held for two cycles while load_valid is asserted
    reset = 1'b0;
    load_valid = 1'b1;
    load_data = 4'hC;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ser_out", ser_out, 1'b0);
    check("rst_ser_valid", ser_valid, 1'b0);
    check("rst_ser_last", ser_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_load_ready", load_ready, 1'b0);
    load_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", load_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

`ifndef PISO_PARITY_EN
    // Single word
    load_valid = 1'b1;
    load_data = 4'b1011;
    wait_accept();
    load_valid = 1'b0;
    expect_stream("single", 4, 16'b1011, 16'b1000);
    @(negedge clk);
    check("single_end_valid", ser_valid, 1'b0);
    check("single_end_busy", busy, 1'b0);
    check("single_end_ready", load_ready, 1'b1);

    // Back-to-back A then 5
    load_valid = 1'b1;
    load_data = 4'hA;
    wait_accept();
    load_data = 4'h5;
    fork
      begin
        wait_accept();
        load_valid = 1'b0;
      end
      expect_stream("b2b", 8, 16'h005A, 16'h0088);
    join
    @(negedge clk);
    check("b2b_end_valid", ser_valid, 1'b0);
    check("b2b_end_busy", busy, 1'b0);

    // Reset mid-frame
    #1;
    load_valid = 1'b1;
    load_data = 4'hF;
    wait_accept();
    load_valid = 1'b0;
    expect_stream("abort_pre", 3, 16'b111, 16'b000);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_valid", ser_valid, 1'b0);
    check("abort_last", ser_last, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", load_ready, 1'b0);
    reset = 1'b1;
    load_valid = 1'b1;
    load_data = 4'h3;
    wait_accept();
    load_valid = 1'b0;
    expect_stream("after_abort", 4, 16'b0011, 16'b1000);

    // Random streaming through the receiver model
    #1;
    load_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      load_data = W'($urandom_range(0, (1 << W) - 1));
      wait_accept();
    end
    load_valid = 1'b0;
`else
    // Parity frame: 0111 gives bits 1,1,1,0 followed by parity 1
    load_valid = 1'b1;
    load_data = 4'b0111;
    wait_accept();
    load_valid = 1'b0;
    expect_stream("parity", 5, 16'b10111, 16'b10000);
    @(negedge clk);
    check("parity_end_valid", ser_valid, 1'b0);
    check("parity_end_busy", busy, 1'b0);

    // Back-to-back parity frames: 1011 (parity 1) then 0011 (parity 0)
    #1;
    load_valid = 1'b1;
    load_data = 4'b1011;
    wait_accept();
    load_data = 4'b0011;
    fork
      begin
        wait_accept();
        load_valid = 1'b0;
      end
      expect_stream("parity_b2b", 10, 16'b00011_11011, 16'b10000_10000);
    join
`endif

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("final_idle", busy, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
